mem_router: RTL
===============

MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 Parameter MEM_W, 32, data bus width in bits; a multiple of 8.
REQ-002 Parameter NUM_REGIONS, 4, number of downstream regions, range 1..16.
REQ-003 Parameter REGION_BASE, {0x100, 0x120, 0x1000, 0x2000}, per-region base address (32-bit array).
REQ-004 Parameter REGION_MASK, {0xFFFF_FFE0, 0xFFFF_FFFC, 0xFFFF_F000, 0xFFFF_E000}, per-region address mask.
REQ-005 Parameter REGION_RO, 4'b1000, per-region read-only flag bit vector.
REQ-006 Parameter TIMEOUT_CYCLES, 255, maximum cycles to wait for a region response, range 1..65535.
REQ-007 Ports: clk in 1, single clock; rst in 1, synchronous active-high reset.
REQ-008 Core side: core_req_i in 1; core_addr_i in 32; core_we_i in 1; core_be_i in MEM_W/8; core_wdata_i in MEM_W; core_gnt_o out 1; core_rvalid_o out 1; core_err_o out 1; core_rdata_o out MEM_W.
REQ-009 Region side: reg_req_o out NUM_REGIONS; reg_addr_o out 32; reg_we_o out 1; reg_be_o out MEM_W/8; reg_wdata_o out MEM_W; reg_rvalid_i in NUM_REGIONS; reg_err_i in NUM_REGIONS; reg_rdata_i in NUM_REGIONS x MEM_W.
REQ-010 Status: busy_o out 1, high when not IDLE; err_count_o out 16, saturating count of error responses.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, with one transaction outstanding at most.
REQ-012 core_gnt_o SHALL be 1 exactly when state is IDLE; a request is accepted when core_req_i and core_gnt_o are both high.
REQ-013 On acceptance, the block SHALL register addr, we, be and wdata, and decode hit[k] = ((addr & REGION_MASK[k]) == REGION_BASE[k]), with the lowest index winning on overlap.
REQ-014 On acceptance with no hit, or with we=1 to a region whose REGION_RO bit is set: next state RESP, with err=1 and rdata=0; no reg_req_o is asserted.
REQ-015 Otherwise: next state ISSUE; in ISSUE, reg_req_o[k] SHALL be high for exactly one cycle, with reg_addr/we/be/wdata driven from the registered values.
REQ-016 reg_addr/we/be/wdata SHALL hold stable from ISSUE until leaving WAIT, and SHALL be 0 in IDLE and RESP.
REQ-017 In ISSUE or WAIT, when reg_err_i[k] is sampled high: next state RESP with err=1 and rdata=0; err takes priority over a simultaneous rvalid.
REQ-018 In ISSUE or WAIT, when reg_rvalid_i[k] (and not err) is sampled high: next state RESP with err=0 and rdata=reg_rdata_i[k]; writes return rdata=0.
REQ-019 ISSUE with no response SHALL go to WAIT.
REQ-020 A 16-bit counter SHALL clear on entering ISSUE and increment each ISSUE/WAIT cycle; when it reaches TIMEOUT_CYCLES with no response: RESP, err=1, rdata=0.
REQ-021 A response arriving in the same cycle as the timeout SHALL win over the timeout.
REQ-022 RESP SHALL last one cycle with core_rvalid_o=1, core_err_o and core_rdata_o registered; it then returns to IDLE. Both reads and writes get exactly one response.
REQ-023 Outside RESP, core_rvalid_o, core_err_o and core_rdata_o SHALL be 0.
REQ-024 Region responses outside ISSUE/WAIT, or from a non-selected region, SHALL be ignored.
REQ-025 err_count_o SHALL increment by 1 on each RESP with err=1 and saturate at 0xFFFF.
REQ-026 Minimum latency SHALL be: accept at cycle 0, reg_req_o at cycle 1, core_rvalid_o at cycle 2. A decode error responds at cycle 1.

Reset
REQ-027 With rst high at a clock edge: state=IDLE; all outputs 0 except core_gnt_o=1 on the following cycle; err_count_o=0; timeout counter=0; registered transaction fields=0.
REQ-028 Reset mid-transaction SHALL drop the transaction without a core response; a late region response after reset SHALL be ignored.

Structure
REQ-029 Package mem_router_pkg SHALL hold the state enum, the default region base/mask/RO constants, and the 16-bit counter width constant.
REQ-030 Address decode SHALL be a combinational sub-module mem_router_decoder, parametrised on NUM_REGIONS, returning a hit flag, region index and RO flag.

Verification
REQ-031 Read 0x1004; region 2 returns rvalid on ISSUE with data 0xDEADBEEF -> reg_req_o=4'b0100 at cycle 1; core_rvalid_o=1 and rdata=0xDEADBEEF at cycle 2.
REQ-032 Write 0x2000 (RO region 3) -> no reg_req_o; core_rvalid_o=1 and core_err_o=1 at cycle 1; err_count_o=1.
REQ-033 Read 0x0800 (no hit) -> err response at cycle 1, rdata=0; a second back-to-back request is accepted the cycle after RESP.
REQ-034 Read 0x0104 with region 0 silent, TIMEOUT_CYCLES=4 -> err response after 4 ISSUE/WAIT cycles; a late reg_rvalid_i[0] in IDLE is ignored.
REQ-035 Region 1 asserts rvalid and err together -> core_err_o=1, rdata=0.
REQ-036 Assert rst during WAIT -> no core_rvalid_o; busy_o=0 and core_gnt_o=1 after reset; forcing 70000 errors leaves err_count_o at 0xFFFF.

Source files
------------

// File: rtl/mem_router_pkg.sv
// Shared types and constants for the memory router: FSM state encoding,
// default region map, and the width of the timeout/error counters.
package mem_router_pkg;

    // Transaction FSM states; at most one transaction is in flight.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width of the timeout counter and of the saturating error counter.
    localparam int CNT_W = 16;

    // Width of a region index; covers up to 16 regions.
    localparam int IDX_W = 4;

    // Default region map, region 0 in the least significant 32-bit word.
    localparam logic [4*32-1:0] DEF_REGION_BASE = {
        32'h0000_2000, 32'h0000_1000, 32'h0000_0120, 32'h0000_0100
    };
    localparam logic [4*32-1:0] DEF_REGION_MASK = {
        32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FFE0
    };
    localparam logic [3:0] DEF_REGION_RO = 4'b1000;

    // All-ones value of a counter; the error count sticks here.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment used by the error counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_router_decoder.sv
// Combinational address decoder: matches an address against every region's
// base/mask pair and reports the lowest-numbered hit and its read-only flag.
module mem_router_decoder
    import mem_router_pkg::*;
#(
    parameter int                        NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS-1:0]    REGION_RO   = DEF_REGION_RO
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic             ro
);

    // Scan from the highest region down so the lowest matching index is the
    // last one written and therefore wins on overlapping regions.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        ro  = 1'b0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if ((addr & REGION_MASK[k*32 +: 32]) == REGION_BASE[k*32 +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
                ro  = REGION_RO[k];
            end
        end
    end

endmodule

// File: rtl/mem_router.sv
// Single-outstanding memory router. Accepts a core request in IDLE, decodes
// it to one downstream region, issues a one-cycle region request, waits for
// the region's response (or a timeout) and returns exactly one response.
//
// Handshake summary: the core side is a req/gnt acceptance (a transfer
// happens on a clock edge where core_req_i and core_gnt_o are both high) and
// a single-cycle core_rvalid_o pulse per accepted request. The region side
// is a single-cycle reg_req_o pulse followed by a single-cycle reg_rvalid_i
// or reg_err_i from the selected region; anything else on the region
// response lines is ignored.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int                        MEM_W          = 32,
    parameter int                        NUM_REGIONS    = 4,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE    = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK    = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS-1:0]    REGION_RO      = DEF_REGION_RO,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,

    // Core side
    input  logic                         core_req_i,
    input  logic [31:0]                  core_addr_i,
    input  logic                         core_we_i,
    input  logic [MEM_W/8-1:0]           core_be_i,
    input  logic [MEM_W-1:0]             core_wdata_i,
    output logic                         core_gnt_o,
    output logic                         core_rvalid_o,
    output logic                         core_err_o,
    output logic [MEM_W-1:0]             core_rdata_o,

    // Region side
    output logic [NUM_REGIONS-1:0]       reg_req_o,
    output logic [31:0]                  reg_addr_o,
    output logic                         reg_we_o,
    output logic [MEM_W/8-1:0]           reg_be_o,
    output logic [MEM_W-1:0]             reg_wdata_o,
    input  logic [NUM_REGIONS-1:0]       reg_rvalid_i,
    input  logic [NUM_REGIONS-1:0]       reg_err_i,
    input  logic [NUM_REGIONS*MEM_W-1:0] reg_rdata_i,

    // Status
    output logic                         busy_o,
    output logic [CNT_W-1:0]             err_count_o
);

    localparam int BE_W = MEM_W / 8;

    // Counter value seen in the last ISSUE/WAIT cycle before timing out.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // FSM state, exposed for debug and checkers.
    state_e                  state;

    // Registered transaction fields.
    logic [31:0]             addr_q;
    logic                    we_q;
    logic [BE_W-1:0]         be_q;
    logic [MEM_W-1:0]        wdata_q;
    logic [NUM_REGIONS-1:0]  sel_q;

    // Registered outputs.
    logic [NUM_REGIONS-1:0]  req_q;
    logic                    rvalid_q;
    logic                    err_q;
    logic [MEM_W-1:0]        rdata_q;

    // Timeout and error counters.
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        err_count_q;

    // Decoder results for the address currently on the core bus.
    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_ro;
    logic [NUM_REGIONS-1:0]  dec_onehot;

    // Response lines of the selected region only.
    logic                    sel_rvalid;
    logic                    sel_err;
    logic [MEM_W-1:0]        sel_rdata;

    logic                    in_flight;
    logic                    accept;
    logic                    reject;

    mem_router_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_RO   (REGION_RO)
    ) u_decoder (
        .addr (core_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx),
        .ro   (dec_ro)
    );

    assign in_flight = (state == ST_ISSUE) || (state == ST_WAIT);
    assign accept    = (state == ST_IDLE) && core_req_i;
    assign reject    = !dec_hit || (core_we_i && dec_ro);

    // Expand the decoded index into a one-hot region select.
    always_comb begin
        dec_onehot = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            dec_onehot[k] = dec_hit && (dec_idx == IDX_W'(k));
        end
    end

    // Mask the region responses down to the selected region.
    always_comb begin
        sel_rvalid = |(reg_rvalid_i & sel_q);
        sel_err    = |(reg_err_i & sel_q);
        sel_rdata  = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (sel_q[k]) begin
                sel_rdata = reg_rdata_i[k*MEM_W +: MEM_W];
            end
        end
    end

    // Transaction FSM with registered core response and region request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            req_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                    if (accept) begin
                        addr_q  <= core_addr_i;
                        we_q    <= core_we_i;
                        be_q    <= core_be_i;
                        wdata_q <= core_wdata_i;
                        if (reject) begin
                            // Decode miss or write to a read-only region:
                            // answer directly without touching any region.
                            sel_q    <= '0;
                            state    <= ST_RESP;
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else begin
                            sel_q <= dec_onehot;
                            req_q <= dec_onehot;
                            cnt_q <= '0;
                            state <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    req_q <= '0;
                    cnt_q <= cnt_q + 1'b1;
                    if (sel_err) begin
                        // Error beats a simultaneous rvalid.
                        state    <= ST_RESP;
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                    end else if (sel_rvalid) begin
                        // A response in the timeout cycle still wins.
                        state    <= ST_RESP;
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b0;
                        rdata_q  <= we_q ? '0 : sel_rdata;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state    <= ST_RESP;
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end

                ST_RESP: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Count error responses, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if ((state == ST_RESP) && err_q) begin
            err_count_q <= sat_inc(err_count_q);
        end else begin
            err_count_q <= err_count_q;
        end
    end

    // Core side outputs.
    assign core_gnt_o    = (state == ST_IDLE);
    assign core_rvalid_o = rvalid_q;
    assign core_err_o    = err_q;
    assign core_rdata_o  = rdata_q;

    // Region side outputs: transaction fields are only visible while the
    // transaction is outstanding, and read as zero otherwise.
    assign reg_req_o   = req_q;
    assign reg_addr_o  = in_flight ? addr_q  : '0;
    assign reg_we_o    = in_flight ? we_q    : 1'b0;
    assign reg_be_o    = in_flight ? be_q    : '0;
    assign reg_wdata_o = in_flight ? wdata_q : '0;

    // Status outputs.
    assign busy_o      = (state != ST_IDLE);
    assign err_count_o = err_count_q;

endmodule
